// File: rtl/regfile_pkg.sv
// Shared register-file constants and types, reused by decode and hazard units.
package regfile_pkg;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);

  typedef logic [RF_ADDR_W-1:0] reg_addr_t;
  typedef logic [RF_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_busy_sb.sv
// Pending-write scoreboard: one busy bit per register, set by reservations,
// cleared by write-back, and masked on the read side when a write is forwarded.
module regfile_busy_sb
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_ok,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic              i_rsv_ok,
  input  logic [ADDR_W-1:0] i_rsv_addr,
  input  logic [ADDR_W-1:0] i_rd_addr1,
  input  logic              i_rd_ok1,
  input  logic              i_fwd1,
  input  logic [ADDR_W-1:0] i_rd_addr2,
  input  logic              i_rd_ok2,
  input  logic              i_fwd2,
  output logic              o_busy1,
  output logic              o_busy2
);
  logic [NUM_REGS-1:0] r_busy;

  // Reservation is applied after the clear so a same-address reserve wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      if (i_wr_ok)  r_busy[i_wr_addr]  <= 1'b0;
      if (i_rsv_ok) r_busy[i_rsv_addr] <= 1'b1;
    end
  end

  assign o_busy1 = i_rd_ok1 && r_busy[i_rd_addr1] && !i_fwd1;
  assign o_busy2 = i_rd_ok2 && r_busy[i_rd_addr2] && !i_fwd2;
endmodule

// File: rtl/regfile_scoreboard_mp.sv
// Register file with two combinational read ports, one write port, optional
// zero register and write-to-read bypass, plus a pending-write scoreboard.
module regfile_scoreboard_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              hazard
);
  // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NUM_REGS_W) && !(ZERO_REG && (a == '0));
  endfunction

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic w_wr_ok, w_rsv_ok, w_rd_ok1, w_rd_ok2, w_fwd1, w_fwd2;

  assign w_wr_ok  = wr_en && addr_ok(wr_addr);
  assign w_rsv_ok = rsv_en && addr_ok(rsv_addr);
  assign w_rd_ok1 = addr_ok(rd_addr1);
  assign w_rd_ok2 = addr_ok(rd_addr2);
  assign w_fwd1   = BYPASS && w_wr_ok && (wr_addr == rd_addr1);
  assign w_fwd2   = BYPASS && w_wr_ok && (wr_addr == rd_addr2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data1 = w_fwd1 ? wr_data : (w_rd_ok1 ? r_regs[rd_addr1] : '0);
  assign rd_data2 = w_fwd2 ? wr_data : (w_rd_ok2 ? r_regs[rd_addr2] : '0);

  regfile_busy_sb #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_busy_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_ok    (w_wr_ok),
    .i_wr_addr  (wr_addr),
    .i_rsv_ok   (w_rsv_ok),
    .i_rsv_addr (rsv_addr),
    .i_rd_addr1 (rd_addr1),
    .i_rd_ok1   (w_rd_ok1),
    .i_fwd1     (w_fwd1),
    .i_rd_addr2 (rd_addr2),
    .i_rd_ok2   (w_rd_ok2),
    .i_fwd2     (w_fwd2),
    .o_busy1    (busy1),
    .o_busy2    (busy2)
  );

  assign hazard = busy1 | busy2;
endmodule

// File: tb/tb_regfile_scoreboard_mp.sv
// Bench for regfile_scoreboard_mp: three configurations share one stimulus
// stream and are checked against an array-based model of the register rules.
module tb_regfile_scoreboard_mp;
  logic        clk;
  logic        rst_n;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr, rsv_addr;
  logic [31:0] wr_data;
  logic        wr_en, rsv_en;

  logic [31:0] d1_0, d2_0, d1_1, d2_1, d1_2, d2_2;
  logic        b1_0, b2_0, hz_0, b1_1, b2_1, hz_1, b1_2, b2_2, hz_2;

  // Config 0: defaults; config 1: no bypass; config 2: 24 registers.
  regfile_scoreboard_mp dut (
    .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d1_0), .rd_data2(d2_0), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy1(b1_0), .busy2(b2_0), .hazard(hz_0));

  regfile_scoreboard_mp #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d1_1), .rd_data2(d2_1), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy1(b1_1), .busy2(b2_1), .hazard(hz_1));

  regfile_scoreboard_mp #(.NUM_REGS(24)) dut_24 (
    .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d1_2), .rd_data2(d2_2), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy1(b1_2), .busy2(b2_2), .hazard(hz_2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  string       step     = "init";

  int          cfg_nregs [3] = '{32, 32, 24};
  bit          cfg_byp   [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] m_regs [3][32];
  bit          m_busy [3][32];

  function automatic bit m_valid(int c, logic [4:0] a);
    return (int'(a) < cfg_nregs[c]) && (a != 5'd0);
  endfunction

  function automatic bit m_fwd(int c, logic [4:0] a);
    return cfg_byp[c] && wr_en && (wr_addr == a) && m_valid(c, a);
  endfunction

  function automatic logic [31:0] exp_data(int c, logic [4:0] a);
    if (m_fwd(c, a)) return wr_data;
    if (!m_valid(c, a)) return 32'd0;
    return m_regs[c][a];
  endfunction

  function automatic logic exp_busy(int c, logic [4:0] a);
    return m_valid(c, a) && m_busy[c][a] && !m_fwd(c, a);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 32; r++) begin
        m_regs[c][r] = 32'd0;
        m_busy[c][r] = 1'b0;
      end
  endtask

  task automatic model_edge();
    if (!rst_n) return;
    for (int c = 0; c < 3; c++) begin
      if (wr_en && m_valid(c, wr_addr)) begin
        m_regs[c][wr_addr] = wr_data;
        m_busy[c][wr_addr] = 1'b0;
      end
      if (rsv_en && m_valid(c, rsv_addr)) m_busy[c][rsv_addr] = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] od1 [3];
    logic [31:0] od2 [3];
    logic        ob1 [3];
    logic        ob2 [3];
    logic        ohz [3];
    logic        e1, e2;
    od1 = '{d1_0, d1_1, d1_2};
    od2 = '{d2_0, d2_1, d2_2};
    ob1 = '{b1_0, b1_1, b1_2};
    ob2 = '{b2_0, b2_1, b2_2};
    ohz = '{hz_0, hz_1, hz_2};
    for (int c = 0; c < 3; c++) begin
      e1 = exp_busy(c, rd_addr1);
      e2 = exp_busy(c, rd_addr2);
      check($sformatf("%s c%0d rd_data1", step, c), od1[c], exp_data(c, rd_addr1));
      check($sformatf("%s c%0d rd_data2", step, c), od2[c], exp_data(c, rd_addr2));
      check($sformatf("%s c%0d busy1", step, c), {31'd0, ob1[c]}, {31'd0, e1});
      check($sformatf("%s c%0d busy2", step, c), {31'd0, ob2[c]}, {31'd0, e2});
      check($sformatf("%s c%0d hazard", step, c), {31'd0, ohz[c]}, {31'd0, e1 | e2});
    end
  endtask

  // Check combinational outputs mid-cycle, then clock and advance the model.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra);
    rd_addr1 = a1; rd_addr2 = a2;
    wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    model_reset();
    #3;
    step = "reset";
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;

    step = "write3";
    drive(5'd0, 5'd0, 1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0);      cycle();
    step = "read3";
    drive(5'd3, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);             cycle();
    step = "write0";
    drive(5'd1, 5'd2, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);      cycle();
    step = "read0";
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);             cycle();
    step = "bypass7";
    drive(5'd3, 5'd7, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0);      cycle();
    step = "read7";
    drive(5'd7, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);             cycle();

    step = "rsv9_t";
    drive(5'd9, 5'd3, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);             cycle();
    step = "rsv9_t1";
    drive(5'd9, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);             cycle();
    step = "rsv9_t2";                                             cycle();
    step = "wr9_t3";
    drive(5'd9, 5'd9, 1'b1, 5'd9, 32'h0BADF00D, 1'b0, 5'd0);      cycle();
    step = "rd9_t4";
    drive(5'd9, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);             cycle();

    step = "simul4";
    drive(5'd4, 5'd1, 1'b1, 5'd4, 32'h44444444, 1'b1, 5'd4);      cycle();
    step = "read4";
    drive(5'd4, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);             cycle();
    step = "rsv0";
    drive(5'd0, 5'd4, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);             cycle();
    step = "read0b";
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);             cycle();

    step = "write30";
    drive(5'd30, 5'd3, 1'b1, 5'd30, 32'h30303030, 1'b1, 5'd30);   cycle();
    step = "read30";
    drive(5'd30, 5'd23, 1'b1, 5'd23, 32'h23232323, 1'b1, 5'd24);  cycle();
    step = "read30b";
    drive(5'd30, 5'd23, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);           cycle();

    step = "prep_reset";
    drive(5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd6);      cycle();
    step = "pre_reset";
    drive(5'd5, 5'd6, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    #1;
    check_all();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    step = "async_reset";
    check_all();
    cycle();
    rst_n = 1'b1;
    step = "after_reset";
    cycle();

    step = "random";
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a1, a2, wa;
      a1 = 5'($urandom_range(0, 31));
      a2 = 5'($urandom_range(0, 31));
      wa = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      drive(a1, a2, 1'($urandom_range(0, 1)), wa, $urandom(),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
